// File: rtl/dmem_io_pkg.sv
// Shared constants and types for the dmem_io data-side responder.
package dmem_io_pkg;

    localparam logic [27:0] IO_PAGE     = 28'hFFFF000;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF0000;
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF0004;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF0008;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF000C;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // STATUS exposes only three count bits.
    function automatic logic [2:0] sat_count(input logic [31:0] c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/dmem_io_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module dmem_io_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
        else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // When full, the write slot equals the head slot; the head was already consumed this edge.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/dmem_io.sv
// Data RAM plus memory-mapped LED, cycle counter and FIFO-buffered 8N1 transmitter.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic        tx
);

    localparam int BW  = $clog2(BAUD_DIV);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     ram_q [2**RAM_AW];
    logic [7:0]      leds_q, leds_d;
    logic [31:0]     cyc_q, cyc_d;
    tx_state_e       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    logic            ram_sel, io_sel, baud_end, fifo_pop, fifo_push;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic [FCW-1:0]  fifo_cnt;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]     status;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign ram_sel  = (addr[31:16] == 16'h0000);
    assign io_sel   = (addr[31:4] == IO_PAGE);
    assign ram_idx  = addr[RAM_AW+1:2];
    assign baud_end = (baud_q == BW'(BAUD_DIV - 1));
    assign leds     = leds_q;
    assign fifo_push = memwrite && io_sel && (addr[3:2] == ADDR_TXDATA[3:2]);

    dmem_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (writedata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (memwrite && ram_sel) ram_q[ram_idx] <= writedata;
    end

    always_comb begin
        status                       = '0;
        status[ST_FULL]              = fifo_full;
        status[ST_EMPTY]             = fifo_empty;
        status[ST_BUSY]              = (state_q != TX_IDLE);
        status[ST_CNT_LSB +: 3]      = sat_count(32'(fifo_cnt));

        readdata = '0;
        if (ram_sel) begin
            readdata = ram_q[ram_idx];
        end else if (io_sel) begin
            case (addr[3:2])
                ADDR_LED[3:2]:    readdata = {24'b0, leds_q};
                ADDR_CYCLES[3:2]: readdata = cyc_q;
                ADDR_STATUS[3:2]: readdata = status;
                default:          readdata = '0;
            endcase
        end
    end

    always_comb begin
        leds_d = leds_q;
        cyc_d  = cyc_q + 32'd1;
        if (memwrite && io_sel && addr[3:2] == ADDR_LED[3:2])    leds_d = writedata[7:0];
        if (memwrite && io_sel && addr[3:2] == ADDR_CYCLES[3:2]) cyc_d  = '0;
    end

    // Baud counter restarts on every state entry so each bit lasts exactly BAUD_DIV cycles.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = TX_START;
                end
            end
            TX_START: if (baud_end) begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: if (baud_end) begin
                baud_d  = '0;
                shift_d = shift_q >> 1;
                if (bit_q == 3'd7) state_d = TX_STOP;
                else               bit_d   = bit_q + 1'b1;
            end
            TX_STOP: if (baud_end) begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = TX_START;
                end else begin
                    state_d  = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q  <= '0;
            cyc_q   <= '0;
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            leds_q  <= leds_d;
            cyc_q   <= cyc_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM decode, LED, cycle counter, TX FIFO and serial framing.
module tb_dmem_io;

    localparam int BAUD  = 16;
    localparam int FRAME = 10 * BAUD;
    localparam logic [31:0] A_LED = 32'hFFFF0000;
    localparam logic [31:0] A_CYC = 32'hFFFF0004;
    localparam logic [31:0] A_TXD = 32'hFFFF0008;
    localparam logic [31:0] A_ST  = 32'hFFFF000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_bytes [8];
    int exp_nb = 0;

    dmem_io #(.RAM_AW(6), .FIFO_DEPTH(4), .BAUD_DIV(BAUD)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        addr = a;
        writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    // Expected line level for interval i counted from the edge that entered the first START.
    function automatic logic exp_tx(input int i);
        int f, seg;
        f = i / FRAME;
        seg = (i % FRAME) / BAUD;
        if (f >= exp_nb) return 1'b1;
        if (seg == 0) return 1'b0;
        if (seg == 9) return 1'b1;
        return exp_bytes[f][seg-1];
    endfunction

    task automatic check_tx_window(input int from, input int to, input string name,
                                   input int push_at, input logic [7:0] push_byte);
        for (int i = from; i < to; i++) begin
            n_cmp++;
            if (tx !== exp_tx(i)) begin
                n_bad++;
                $display("FAIL %s tx interval %0d: got %b want %b", name, i, tx, exp_tx(i));
            end
            if (i == push_at) begin
                memwrite = 1'b1;
                addr = A_TXD;
                writedata = {24'b0, push_byte};
            end
            tick();
            memwrite = 1'b0;
        end
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        n_cmp++;
        if (readdata !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, readdata, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++;
        if (leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds: got %h want 00", leds); end
        rd_check(A_ST, 32'h2, "reset_status");
        rd_check(A_CYC, 32'h0, "reset_cycles");
        reset = 1'b0;
    endtask

    task automatic test_counter();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (100) tick();
        rd_check(A_CYC, 32'd100, "cycles_100");
        wr(A_CYC, 32'h0000FFFF);
        rd_check(A_CYC, 32'd0, "cycles_clear");
        repeat (5) tick();
        rd_check(A_CYC, 32'd5, "cycles_after_clear");
    endtask

    task automatic test_ram();
        wr(32'h0000_0010, 32'hDEADBEEF);
        rd_check(32'h0000_0010, 32'hDEADBEEF, "ram_read");
        rd_check(32'h0000_0110, 32'hDEADBEEF, "ram_alias");
        rd_check(32'h1000_0000, 32'h0, "unmapped_read");
        wr(32'h1000_0010, 32'h00000123);
        rd_check(32'h0000_0010, 32'hDEADBEEF, "unmapped_write_ignored");
        wr(32'h0000_0014, 32'hCAFEF00D);
        rd_check(32'h0000_0014, 32'hCAFEF00D, "ram_next_word");
    endtask

    task automatic test_led();
        wr(A_LED, 32'h000001A5);
        n_cmp++;
        if (leds !== 8'hA5) begin n_bad++; $display("FAIL led_port: got %h want a5", leds); end
        rd_check(A_LED, 32'h000000A5, "led_read");
        rd_check(A_TXD, 32'h0, "txdata_read");
        rd_check(A_ST, 32'h2, "led_no_push");
        rd_check(32'hFFFF0010, 32'h0, "io_outside_page");
    endtask

    task automatic test_tx_single();
        exp_bytes[0] = 8'h55;
        exp_nb = 1;
        wr(A_TXD, 32'h55);
        rd_check(A_ST, 32'h10, "single_status_queued");
        tick();
        check_tx_window(0, 80, "single", -1, 8'h00);
        rd_check(A_ST, 32'h06, "single_status_busy");
        check_tx_window(80, FRAME + 10, "single", -1, 8'h00);
        rd_check(A_ST, 32'h02, "single_status_idle");
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 5; b++) exp_bytes[b] = 8'(b + 1);
        exp_nb = 5;
        for (int b = 1; b <= 6; b++) wr(A_TXD, 32'(b));
        rd_check(A_ST, 32'h45, "overflow_status_full");
        check_tx_window(4, 5 * FRAME + 10, "overflow", -1, 8'h00);
        rd_check(A_ST, 32'h02, "overflow_status_idle");
    endtask

    task automatic test_push_on_pop();
        for (int b = 0; b < 5; b++) exp_bytes[b] = 8'(8'h11 * (b + 1));
        exp_bytes[5] = 8'h66;
        exp_nb = 6;
        for (int b = 0; b < 5; b++) wr(A_TXD, 32'(exp_bytes[b]));
        check_tx_window(3, FRAME - 1, "push_on_pop", -1, 8'h00);
        rd_check(A_ST, 32'h45, "pop_edge_status_before");
        check_tx_window(FRAME - 1, FRAME, "push_on_pop", FRAME - 1, 8'h66);
        rd_check(A_ST, 32'h45, "pop_edge_status_after");
        check_tx_window(FRAME, 6 * FRAME + 10, "push_on_pop", -1, 8'h00);
        rd_check(A_ST, 32'h02, "pop_edge_status_idle");
    endtask

    task automatic test_reset_mid_frame();
        wr(32'h0000_0020, 32'h12345678);
        wr(A_LED, 32'h3C);
        wr(A_TXD, 32'hA5);
        repeat (71) tick();
        n_cmp++;
        if (tx !== 1'b0) begin n_bad++; $display("FAIL midframe_bit3: got %b want 0", tx); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL midframe_tx: got %b want 1", tx); end
        n_cmp++;
        if (leds !== 8'h00) begin n_bad++; $display("FAIL midframe_leds: got %h want 00", leds); end
        rd_check(A_ST, 32'h02, "midframe_status");
        rd_check(32'h0000_0020, 32'h12345678, "midframe_ram_kept");
        rd_check(32'h0000_0010, 32'hDEADBEEF, "midframe_ram_old");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL post_reset_tx: got %b want 1", tx); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_led();
        test_tx_single();
        test_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
